cond_resolve: RTL

COND_RESOLVE -- requirements
Module: cond_resolve

---
 rtl/cond_resolve.sv | 126 ++++++++++++
 1 files changed

// File: rtl/cond_resolve.sv
// rtl/cond_resolve.sv - set-condition / branch resolve stage, one-cycle latency.
// Optional squash FSM compiled in with COND_RESOLVE_SQUASH_EN.
module cond_resolve #(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        stall,
  input  logic [0:2]  op,
  input  logic        seq,
  input  logic        sne,
  input  logic        slt,
  input  logic        sgt,
  input  logic        sle,
  input  logic        sge,
  input  logic [0:31] pc_plus4,
  input  logic [0:31] imm,
  input  logic [0:4]  rd,
  output logic        out_valid,
  output logic [0:31] set_result,
  output logic        wr_en,
  output logic [0:4]  wr_rd,
  output logic        redirect,
  output logic [0:31] redirect_pc,
  output logic        squash
);

  logic        accept, taken, flag, is_set;
  logic [0:31] target;

  logic        valid_q, valid_d, wen_q, wen_d, redir_q, redir_d;
  logic [0:31] set_q, set_d, rpc_q, rpc_d;
  logic [0:4]  rd_q, rd_d;

  always_comb begin
    flag = 1'b0;
    case (op)
      3'd0: flag = seq;
      3'd1: flag = sne;
      3'd2: flag = slt;
      3'd3: flag = sgt;
      3'd4: flag = sle;
      3'd5: flag = sge;
      default: flag = 1'b0;
    endcase
  end

  assign is_set = (op < 3'd6);
  assign target = pc_plus4 + imm;
  assign accept = in_valid & ~squash;
  assign taken  = accept & (((op == 3'd6) & seq) | ((op == 3'd7) & sne));

`ifdef COND_RESOLVE_SQUASH_EN
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  assign squash = (state_q == SQUASH);

  // counter counts the younger slots still to be thrown away
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == SQUASH) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q <= 3'd1) begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    end else if (taken) begin
      state_d = SQUASH;
      cnt_d   = SQUASH_DEPTH[2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else if (!stall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign squash = 1'b0;
`endif

  always_comb begin
    valid_d = accept;
    wen_d   = accept & is_set;
    set_d   = (accept && is_set) ? {31'd0, flag} : 32'd0;
    rd_d    = accept ? rd : 5'd0;
    redir_d = taken;
    rpc_d   = taken ? target : 32'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      set_q   <= 32'd0;
      rd_q    <= 5'd0;
      redir_q <= 1'b0;
      rpc_q   <= 32'd0;
    end else if (!stall) begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      set_q   <= set_d;
      rd_q    <= rd_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
    end
  end

  assign out_valid   = valid_q;
  assign wr_en       = wen_q;
  assign set_result  = set_q;
  assign wr_rd       = rd_q;
  assign redirect    = redir_q;
  assign redirect_pc = rpc_q;

endmodule
